// File: rtl/acc_drain_if.sv
// Output stream from a row drain to the output buffer: one scaled result per
// valid/ready handshake, tagged with its PE index and an end-of-row marker.
interface acc_drain_if #(
    parameter int OUT_WIDTH = 16,
    parameter int IDX_W     = 2
);
    logic [OUT_WIDTH-1:0] out_data_o;
    logic [IDX_W-1:0]     out_idx_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 out_last_o;

    modport master (
        output out_data_o,
        output out_idx_o,
        output out_valid_o,
        output out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_data_o,
        input  out_idx_o,
        input  out_valid_o,
        input  out_last_o,
        output out_ready_i
    );
endinterface

// File: rtl/acc_drain.sv
// Row drain: snapshots NUM_PE signed accumulators on command, then streams
// each one arithmetically shifted and saturated to OUT_WIDTH.
//
// state  | meaning
// IDLE   | waiting for drain_start_i
// STREAM | presenting beat idx_q, advancing on each handshake
// DONE   | one-cycle done_o pulse, then back to IDLE
module acc_drain #(
    parameter int NUM_PE    = 4,
    parameter int ACC_WIDTH = 64,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        drain_start_i,
    input  logic [NUM_PE*ACC_WIDTH-1:0] acc_i,
    acc_drain_if.master                 out_if,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        sat_o
);
    localparam int IDX_W = $clog2(NUM_PE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d, nxt_idx;
    logic [ACC_WIDTH-1:0]   snap_q [NUM_PE];
    logic [ACC_WIDTH-1:0]   snap_d [NUM_PE];
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic                   bsat_q, bsat_d;
    logic                   sat_q, sat_d;

    // Returns {saturated, value}; the value is clamped whenever the bits above
    // the output sign bit are not a pure sign extension.
    function automatic logic [OUT_WIDTH:0] sat_fn(input logic [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0]   sh;
        logic [ACC_WIDTH-OUT_WIDTH:0]  hi;
        sh = $signed(v) >>> SHIFT;
        hi = sh[ACC_WIDTH-1:OUT_WIDTH-1];
        if (&hi || ~|hi)
            sat_fn = {1'b0, sh[OUT_WIDTH-1:0]};
        else if (sh[ACC_WIDTH-1])
            sat_fn = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            sat_fn = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
    endfunction

    assign nxt_idx = idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            bsat_q  <= 1'b0;
            sat_q   <= 1'b0;
            for (int k = 0; k < NUM_PE; k++) snap_q[k] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            bsat_q  <= bsat_d;
            sat_q   <= sat_d;
            for (int k = 0; k < NUM_PE; k++) snap_q[k] <= snap_d[k];
        end
    end

    // Beat data is registered one step ahead: lane 0 straight from acc_i at
    // the capture edge, later lanes from the snapshot on each handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        bsat_d  = bsat_q;
        sat_d   = sat_q;
        for (int k = 0; k < NUM_PE; k++) snap_d[k] = snap_q[k];
        case (state_q)
            IDLE: begin
                if (drain_start_i) begin
                    for (int k = 0; k < NUM_PE; k++) snap_d[k] = acc_i[k*ACC_WIDTH +: ACC_WIDTH];
                    idx_d            = '0;
                    sat_d            = 1'b0;
                    {bsat_d, data_d} = sat_fn(acc_i[ACC_WIDTH-1:0]);
                    state_d          = STREAM;
                end
            end
            STREAM: begin
                if (out_if.out_ready_i) begin
                    sat_d = sat_q | bsat_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d            = nxt_idx;
                        {bsat_d, data_d} = sat_fn(snap_q[nxt_idx]);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign out_if.out_data_o  = data_q;
    assign out_if.out_idx_o   = idx_q;
    assign out_if.out_valid_o = (state_q == STREAM);
    assign out_if.out_last_o  = (state_q == STREAM) && (idx_q == LAST_IDX);
    assign busy_o             = (state_q != IDLE);
    assign done_o             = (state_q == DONE);
    assign sat_o              = sat_q;
endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: hand-computed beats for normal, saturating,
// backpressured, isolated, ignored-start and reset-abort drains.
module tb_acc_drain;
    logic         clk = 1'b0;
    logic         rstn;
    logic         drain_start_i;
    logic [255:0] acc_i;
    logic         busy_o, done_o, sat_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_d [4];
    bit          exp_f [4];

    acc_drain_if #(.OUT_WIDTH(16), .IDX_W(2)) dif ();

    acc_drain #(.NUM_PE(4), .ACC_WIDTH(64), .OUT_WIDTH(16), .SHIFT(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .drain_start_i (drain_start_i),
        .acc_i         (acc_i),
        .out_if        (dif.master),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .sat_o         (sat_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acc(input logic [63:0] l0, input logic [63:0] l1,
                           input logic [63:0] l2, input logic [63:0] l3);
        acc_i = {l3, l2, l1, l0};
    endtask

    task automatic set_exp(input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3,
                           input bit f0, input bit f1, input bit f2, input bit f3);
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
        exp_f[0] = f0; exp_f[1] = f1; exp_f[2] = f2; exp_f[3] = f3;
    endtask

    task automatic start();
        dif.out_ready_i = 1'b1;
        drain_start_i   = 1'b1;
        tick();
        drain_start_i   = 1'b0;
        chk("start_latency_valid", dif.out_valid_o, 1);
    endtask

    // Consumes one drain; stalls beat stall_idx for stall_n cycles, optionally
    // scrambles acc_i right after the capture edge or re-pulses start on beat 1.
    task automatic drain(input int stall_idx, input int stall_n, input bit chg, input bit start_at1);
        int nb = 0, vcnt = 0, ndone = 0, stalls = stall_n;
        bit cum = 0, last_hs = 0, hs_last;
        for (int t = 0; t < 40 && ndone == 0; t++) begin
            drain_start_i = 1'b0;
            if (chg && t == 0) acc_i = {4{64'h0123_4567_89AB_CDEF}};
            hs_last = 1'b0;
            if (dif.out_valid_o) begin
                vcnt++;
                if (nb > 3) begin
                    chk("extra_beat", nb, 3);
                    dif.out_ready_i = 1'b1;
                end else begin
                    chk("beat_idx", dif.out_idx_o, nb);
                    chk("beat_data", dif.out_data_o, exp_d[nb]);
                    chk("beat_last", dif.out_last_o, nb == 3);
                    chk("beat_sat_sticky", sat_o, cum);
                    chk("beat_busy", busy_o, 1);
                    if (start_at1 && nb == 1) drain_start_i = 1'b1;
                    if (nb == stall_idx && stalls > 0) begin
                        dif.out_ready_i = 1'b0;
                        stalls--;
                    end else begin
                        dif.out_ready_i = 1'b1;
                        hs_last = dif.out_last_o;
                        cum |= exp_f[nb];
                        nb++;
                    end
                end
            end
            if (done_o) begin
                ndone++;
                chk("done_after_last", last_hs, 1);
                chk("done_busy", busy_o, 1);
                chk("done_valid_low", dif.out_valid_o, 0);
                chk("done_sat", sat_o, cum);
            end
            last_hs = hs_last;
            tick();
        end
        drain_start_i   = 1'b0;
        dif.out_ready_i = 1'b1;
        chk("done_seen", ndone, 1);
        chk("beats", nb, 4);
        chk("valid_cycles", vcnt, 4 + stall_n);
        chk("post_busy", busy_o, 0);
        for (int i = 0; i < 3; i++) begin
            chk("post_no_done", done_o, 0);
            chk("post_no_valid", dif.out_valid_o, 0);
            tick();
        end
    endtask

    initial begin
        rstn            = 1'b1;
        drain_start_i   = 1'b0;
        dif.out_ready_i = 1'b1;
        acc_i           = '0;
        tick();
        tick();
        rstn = 1'b0;
        tick();
        chk("rst_valid", dif.out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_sat", sat_o, 0);
        chk("rst_data", dif.out_data_o, 0);
        chk("rst_idx", dif.out_idx_o, 0);
        chk("rst_last", dif.out_last_o, 0);

        // basic drain
        set_acc(64'h0, -64'sh100, 64'h200, 64'h400);
        set_exp(16'h0000, 16'hFFFF, 16'h0002, 16'h0004, 0, 0, 0, 0);
        start();
        drain(-1, 0, 0, 0);

        // saturation both ways plus floor rounding of negatives
        set_acc(64'h7FFF_FFFF, -64'sh7FFF_FFFF, 64'h100, -64'sh101);
        set_exp(16'h7FFF, 16'h8000, 16'h0001, 16'hFFFE, 1, 1, 0, 0);
        start();
        drain(-1, 0, 0, 0);
        chk("sat_held_idle", sat_o, 1);

        // exact range edges do not saturate, one step beyond does
        set_acc(64'h7F_FFFF, -64'sh80_0000, 64'h80_0000, -64'sh80_0001);
        set_exp(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 0, 0, 1, 1);
        start();
        chk("sat_cleared_on_start", sat_o, 0);
        drain(-1, 0, 0, 0);

        // backpressure on beat 2
        set_acc(64'h0, -64'sh100, 64'h200, 64'h400);
        set_exp(16'h0000, 16'hFFFF, 16'h0002, 16'h0004, 0, 0, 0, 0);
        start();
        drain(2, 3, 0, 0);

        // snapshot isolation
        set_acc(64'h1234_00, -64'sh500, 64'h7F00, 64'h0);
        set_exp(16'h1234, 16'hFFFB, 16'h007F, 16'h0000, 0, 0, 0, 0);
        start();
        drain(-1, 0, 1, 0);

        // start during beat 1 is ignored
        set_acc(64'h300, 64'h400, 64'h500, 64'h600);
        set_exp(16'h0003, 16'h0004, 16'h0005, 16'h0006, 0, 0, 0, 0);
        start();
        drain(-1, 0, 0, 1);

        // reset mid-drain
        set_acc(64'h7FFF_FFFF, 64'h0, 64'h200, 64'h400);
        start();
        tick();
        chk("rstmid_sat_before", sat_o, 1);
        chk("rstmid_idx1", dif.out_idx_o, 1);
        tick();
        chk("rstmid_idx2", dif.out_idx_o, 2);
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        chk("rstmid_valid", dif.out_valid_o, 0);
        chk("rstmid_busy", busy_o, 0);
        chk("rstmid_done", done_o, 0);
        chk("rstmid_sat", sat_o, 0);
        chk("rstmid_idx", dif.out_idx_o, 0);
        chk("rstmid_data", dif.out_data_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_no_done", done_o, 0);
        end

        set_acc(64'h0, -64'sh100, 64'h200, 64'h400);
        set_exp(16'h0000, 16'hFFFF, 16'h0002, 16'h0004, 0, 0, 0, 0);
        start();
        drain(-1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/acc_drain.md
Name: acc_drain

Overview:
- Read-side counterpart of the PE accumulator output: snapshots the signed `acc_o` values of one row of NUM_PE processing elements on command.
- Scales and saturates each value to OUT_WIDTH.
- Streams the results out one per handshake over a valid/ready interface to the output buffer.
- Sits at the east edge of each systolic-array row; one instance per row.

Parameters:
- NUM_PE, 4, number of PE accumulators drained per row (≥2).
- ACC_WIDTH, 64, width of each PE accumulator (matches PE ACC_WIDTH).
- OUT_WIDTH, 16, width of each streamed result (< ACC_WIDTH).
- SHIFT, 8, arithmetic right-shift applied before saturation (0 ≤ SHIFT < ACC_WIDTH).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rstn  in  1  reset; synchronous, active-high (1 = reset).
- drain_start_i  in  1  single-cycle request to snapshot and drain the row.
- acc_i  in  NUM_PE*ACC_WIDTH  signed PE accumulators; PE k occupies bits [k*ACC_WIDTH +: ACC_WIDTH].
- out_data_o  out  OUT_WIDTH  scaled, saturated signed result.
- out_idx_o  out  $clog2(NUM_PE)  PE index of out_data_o.
- out_valid_o  out  1  out_data_o/out_idx_o/out_last_o valid.
- out_ready_i  in  1  downstream accepts when high together with out_valid_o.
- out_last_o  out  1  high with the beat for index NUM_PE-1.
- busy_o  out  1  high in STREAM and DONE.
- done_o  out  1  one-cycle pulse after the final beat is accepted.
- sat_o  out  1  sticky: any beat of the current drain saturated; cleared on the next accepted start.

Behaviour:
- Reset (rstn=1 at an edge): state=IDLE, index=0, snapshot regs cleared, all outputs 0.
  - Reset mid-STREAM aborts the drain immediately.
  - The beat in flight is dropped; no done_o pulse.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - drain_start_i=1 at an edge → capture all NUM_PE lanes of acc_i into snapshot registers that same edge; index=0; sat_o=0; go to STREAM.
- STREAM:
  - out_valid_o=1 from the first cycle in STREAM, so latency from start to first valid is 1 cycle.
  - out_data_o = sat(snapshot[index] >>> SHIFT).
  - Saturation: if the shifted value exceeds 2^(OUT_WIDTH-1)-1, clamp to that maximum. If it is below -2^(OUT_WIDTH-1), clamp to that minimum. Otherwise output the low OUT_WIDTH bits.
  - Shift is arithmetic and truncates toward −∞.
  - out_data_o is registered; compute the next-index value ahead of time so data is never combinational from acc_i.
  - Handshake (out_valid_o & out_ready_i at an edge):
    - sat_o |= saturation flag of the current beat.
    - If index == NUM_PE-1 → go to DONE, out_valid_o drops next cycle.
    - Else index+1 and the next beat is presented next cycle.
  - Back-to-back beats occur while out_ready_i is held high: NUM_PE beats in NUM_PE cycles.
  - While out_valid_o=1 and out_ready_i=0, out_data_o/out_idx_o/out_last_o hold stable.
  - out_valid_o never deasserts without a handshake.
- DONE: done_o=1 for exactly one cycle, busy_o=1, out_valid_o=0; next state IDLE.
- drain_start_i in STREAM or DONE is ignored and not queued.
- Snapshot isolation: changes on acc_i after the capture edge do not affect any beat of the current drain.
- Minimum start-to-start spacing is NUM_PE+2 cycles (start, NUM_PE beats, DONE).

Test Plan:
- Basic drain: NUM_PE=4, SHIFT=8, acc_i = {0x400, 0x200, -0x100, 0x0}, out_ready_i=1, pulse start.
  - Beats idx0..3 = 0x0000, 0xFFFF(-1), 0x0002, 0x0004 on consecutive cycles; last on idx3.
  - done_o one cycle after beat 3; sat_o=0.
- Saturation: lane0=0x7FFFFFFF, lane1=-0x7FFFFFFF.
  - idx0 = 0x7FFF, idx1 = 0x8000; sat_o=1 after beat 1 and held until the next start.
- Backpressure: out_ready_i=0 for 3 cycles on beat 2.
  - out_valid_o stays 1 and data/idx=2 stay stable.
  - Total drain = 7 cycles; done_o after beat 3.
- Snapshot isolation: change all acc_i lanes on the cycle after start.
  - Streamed values equal the pre-change values.
- Ignored start: pulse drain_start_i during beat 1.
  - Exactly 4 beats and one done_o; busy_o low afterward.
- Reset mid-drain: assert rstn during beat 2 for one cycle.
  - Next cycle: out_valid_o=0, busy_o=0, no done_o, sat_o=0.
  - A subsequent start drains normally from idx0.
